i3c_sdr_writer: RTL and testbench
=================================

I3C_SDR_WRITER -- requirements
Module: i3c_sdr_writer

Interface
REQ-001 Parameter CLK_DIV, default 4, clk cycles per SCL half-period; legal values 2..255.
REQ-002 clk  in  1  system clock; all state updates on its rising edge.
REQ-003 rst_i  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  frame request; sampled only in IDLE.
REQ-005 addr  in  7  target dynamic address; latched when start is accepted.
REQ-006 tx_data  in  8  payload byte.
REQ-007 tx_valid  in  1  tx_data/tx_last valid.
REQ-008 tx_last  in  1  current byte is the final byte of the frame.
REQ-009 tx_ready  out  1  controller accepts a byte; transfer occurs on tx_valid&&tx_ready.
REQ-010 scl  out  1  I3C SCL, push-pull.
REQ-011 sda_o  out  1  drives I of the I3C_IOBUF on SDA; in open-drain, 1 = release.
REQ-012 sda_modesel  out  1  drives MODESEL of the I3C_IOBUF; 1 = push-pull, 0 = open-drain.
REQ-013 sda_i  in  1  from O of the I3C_IOBUF; sampled SDA level.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse on frame completion.
REQ-016 nack  out  1  address NACK seen in the last frame; held until the next accepted start.

Function
REQ-017 Half-period timer: counter 0..CLK_DIV-1, cleared on every state/phase entry; tick = counter==CLK_DIV-1; the timer stops in IDLE and LOAD.
REQ-018 States: IDLE, START, ADDR, ACK, LOAD, DATA, TBIT, STOP.
REQ-019 IDLE: scl=1, sda_o=1, sda_modesel=0, tx_ready=0.
REQ-020 IDLE, start=1: latch addr, clear nack, enter START next cycle. start in any other state is ignored.
REQ-021 START: one half-period with scl=1, sda_o=0, open-drain; on tick go to ADDR.
REQ-022 Bit slot = a low half-period followed by a high half-period.
REQ-023 During the low half-period scl=0; sda_o is updated on the cycle the slot is entered.
REQ-024 During the high half-period scl=1; sda_i is sampled on the tick ending the high half.
REQ-025 ADDR: 8 open-drain slots, MSB first: addr[6..0], then RnW=0.
REQ-026 ACK: one open-drain slot with sda_o=1; sampled 0 -> LOAD; sampled 1 -> set nack, go to STOP.
REQ-027 LOAD: scl=0, sda_o holds its previous value, tx_ready=1; remain until tx_valid.
REQ-028 On the LOAD handshake: capture byte and last; go to DATA next cycle.
REQ-029 DATA: 8 push-pull slots, MSB first; sda_modesel rises at entry to the first low half only, never while scl=1.
REQ-030 TBIT: one push-pull slot, T = XNOR-reduce of the byte (odd parity over 9 bits); at its end go to STOP if last, else LOAD.
REQ-031 STOP, half 1: scl=0, sda_o=0, sda_modesel=0.
REQ-032 STOP, half 2: scl=1, sda_o=0.
REQ-033 STOP, half 3: scl=1, sda_o=1.
REQ-034 STOP exit: on the tick after half 3 enter IDLE; done=1 on the first IDLE cycle.
REQ-035 Frame duration: with tx_valid held high, a 1-byte frame spans 40*CLK_DIV+1 cycles from START entry to IDLE entry.
REQ-036 All outputs are registered and glitch-free; sda_modesel never changes while scl=1.

Reset
REQ-037 rst_i=0 immediately forces IDLE, counter=0, scl=1, sda_o=1, sda_modesel=0, tx_ready=0, busy=0, done=0, nack=0, including mid-frame.
REQ-038 After rst_i rises, the first start is accepted in the next clk cycle.

Verification
REQ-039 CLK_DIV=4, addr=7'h2A, one byte 8'hA5 with last=1, target ACKs -> SDA shows 0101010 0, ACK, 10100101, T=1; done is 161 cycles after START entry.
REQ-040 Byte 8'h07, last=1 -> T=0; sda_modesel=1 exactly across the DATA and TBIT slots.
REQ-041 sda_i held 1 during ACK -> nack=1, no tx_ready, STOP then done; next start clears nack.
REQ-042 Two bytes with tx_valid delayed 10 cycles before byte 2 -> scl held low and tx_ready=1 for 10 cycles, then the frame resumes intact.
REQ-043 rst_i low during DATA bit 3 -> all outputs at idle values asynchronously; start after release produces a clean frame.
REQ-044 start pulsed while busy -> ignored; latched addr unchanged; exactly one done.

Source files
------------

// File: rtl/i3c_sdr_writer.sv
// rtl/i3c_sdr_writer.sv - I3C SDR private-write controller: START, address, ACK, data bytes with T-bit, STOP.
// All pad-facing outputs are registered and derived from the next state so they change together with it.
module i3c_sdr_writer #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       scl,
  output logic       sda_o,
  output logic       sda_modesel,
  input  logic       sda_i,
  output logic       busy,
  output logic       done,
  output logic       nack
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] ADDR  = 3'd2;
  localparam logic [2:0] ACK   = 3'd3;
  localparam logic [2:0] LOAD  = 3'd4;
  localparam logic [2:0] DATA  = 3'd5;
  localparam logic [2:0] TBIT  = 3'd6;
  localparam logic [2:0] STOP  = 3'd7;

  localparam logic [7:0] TICK_VAL = 8'(CLK_DIV - 1);

  logic [2:0] state_q, state_d;
  logic [1:0] half_q, half_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] byte_q, byte_d;
  logic       last_q, last_d;
  logic       scl_q, scl_d;
  logic       sda_q, sda_d;
  logic       msel_q, msel_d;
  logic       rdy_q, rdy_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       nack_q, nack_d;

  logic       timer_run;
  logic       tick;
  logic [7:0] addr_bits;

  assign timer_run = (state_q != IDLE) && (state_q != LOAD);
  assign tick      = timer_run && (cnt_q == TICK_VAL);

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    bit_d   = bit_q;
    addr_d  = addr_q;
    byte_d  = byte_q;
    last_d  = last_q;
    nack_d  = nack_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = addr;
          nack_d  = 1'b0;
          state_d = START;
          half_d  = 2'd0;
        end
      end
      START: begin
        if (tick) begin
          state_d = ADDR;
          half_d  = 2'd0;
          bit_d   = 3'd0;
        end
      end
      ADDR, DATA: begin
        if (tick) begin
          if (half_q == 2'd0) begin
            half_d = 2'd1;
          end else if (bit_q == 3'd7) begin
            state_d = (state_q == ADDR) ? ACK : TBIT;
            half_d  = 2'd0;
          end else begin
            bit_d  = bit_q + 3'd1;
            half_d = 2'd0;
          end
        end
      end
      ACK: begin
        if (tick) begin
          if (half_q == 2'd0) begin
            half_d = 2'd1;
          end else if (sda_i) begin
            nack_d  = 1'b1;
            state_d = STOP;
            half_d  = 2'd0;
          end else begin
            state_d = LOAD;
            half_d  = 2'd0;
          end
        end
      end
      LOAD: begin
        if (tx_valid && rdy_q) begin
          byte_d  = tx_data;
          last_d  = tx_last;
          state_d = DATA;
          half_d  = 2'd0;
          bit_d   = 3'd0;
        end
      end
      TBIT: begin
        if (tick) begin
          if (half_q == 2'd0) begin
            half_d = 2'd1;
          end else begin
            state_d = last_q ? STOP : LOAD;
            half_d  = 2'd0;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (half_q == 2'd2) begin
            state_d = IDLE;
            half_d  = 2'd0;
            done_d  = 1'b1;
          end else begin
            half_d = half_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin levels follow the state being entered; LOAD parks the clock low and keeps SDA as it was.
  always_comb begin
    addr_bits = {addr_d, 1'b0};
    scl_d     = scl_q;
    sda_d     = sda_q;
    msel_d    = msel_q;

    case (state_d)
      IDLE: begin
        scl_d  = 1'b1;
        sda_d  = 1'b1;
        msel_d = 1'b0;
      end
      START: begin
        scl_d  = 1'b1;
        sda_d  = 1'b0;
        msel_d = 1'b0;
      end
      ADDR: begin
        scl_d  = half_d[0];
        sda_d  = addr_bits[3'd7 - bit_d];
        msel_d = 1'b0;
      end
      ACK: begin
        scl_d  = half_d[0];
        sda_d  = 1'b1;
        msel_d = 1'b0;
      end
      LOAD: begin
        scl_d = 1'b0;
      end
      DATA: begin
        scl_d  = half_d[0];
        sda_d  = byte_d[3'd7 - bit_d];
        msel_d = 1'b1;
      end
      TBIT: begin
        scl_d  = half_d[0];
        sda_d  = ~^byte_d;
        msel_d = 1'b1;
      end
      STOP: begin
        scl_d  = (half_d != 2'd0);
        sda_d  = (half_d == 2'd2);
        msel_d = 1'b0;
      end
      default: begin
        scl_d  = 1'b1;
        sda_d  = 1'b1;
        msel_d = 1'b0;
      end
    endcase

    rdy_d  = (state_d == LOAD);
    busy_d = (state_d != IDLE);

    if ((state_d != state_q) || (half_d != half_q) || (bit_d != bit_q) || !timer_run) begin
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      half_q  <= 2'd0;
      bit_q   <= 3'd0;
      cnt_q   <= 8'd0;
      addr_q  <= 7'd0;
      byte_q  <= 8'd0;
      last_q  <= 1'b0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      msel_q  <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      msel_q  <= msel_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      nack_q  <= nack_d;
    end
  end

  assign tx_ready    = rdy_q;
  assign scl         = scl_q;
  assign sda_o       = sda_q;
  assign sda_modesel = msel_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign nack        = nack_q;

endmodule

// File: tb/tb_i3c_sdr_writer.sv
// tb/tb_i3c_sdr_writer.sv - directed vector bench for i3c_sdr_writer.
module tb_i3c_sdr_writer;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       start;
  logic [6:0] addr;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       sda_i;
  logic       tx_ready, scl, sda_o, sda_modesel, busy, done, nack;

  i3c_sdr_writer #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst_i(rst_i), .start(start), .addr(addr), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready), .scl(scl),
    .sda_o(sda_o), .sda_modesel(sda_modesel), .sda_i(sda_i), .busy(busy),
    .done(done), .nack(nack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] a;
    logic [7:0] d;
    bit         nk;
    logic       t;
    int         len;
  } vec_t;

  vec_t tbl[5];

  int   errors = 0;
  int   checks = 0;
  int   cyc, rises, ready_cnt, msel_cnt, done_cnt, start_cyc, done_cyc, glitch;
  int   nb, idx, gap, wait_cnt;
  bit   waiting, hs_pend, tgt_nack;
  logic scl_p, msel_p, busy_p;
  logic [7:0] bytes_v[2];
  logic bits[$];
  logic msels[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (hs_pend) begin
      hs_pend = 1'b0;
      idx++;
      if (idx < nb) begin
        tx_data = bytes_v[idx];
        tx_last = (idx == nb - 1);
        if (gap > 0) begin
          tx_valid = 1'b0;
          waiting  = 1'b1;
          wait_cnt = 0;
        end
      end else begin
        tx_valid = 1'b0;
      end
    end
    if (scl && !scl_p) begin
      bits.push_back(sda_o);
      msels.push_back(sda_modesel);
      rises++;
    end
    if (scl && scl_p && (sda_modesel !== msel_p)) glitch++;
    if (tx_ready) ready_cnt++;
    if (sda_modesel) msel_cnt++;
    if (busy && !busy_p) start_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (waiting && tx_ready) begin
      wait_cnt++;
      if (wait_cnt == gap) begin
        tx_valid = 1'b1;
        waiting  = 1'b0;
      end
    end
    hs_pend = tx_ready && tx_valid;
    sda_i   = ((rises == 8) || (rises == 9 && scl)) ? tgt_nack : sda_o;
    scl_p   = scl;
    msel_p  = sda_modesel;
    busy_p  = busy;
  endtask

  task automatic init_frame(input logic [6:0] a, input logic [7:0] b0, input logic [7:0] b1,
                            input int n, input bit nk, input int g);
    cyc = 0; rises = 0; ready_cnt = 0; msel_cnt = 0; done_cnt = 0;
    start_cyc = 0; done_cyc = 0; glitch = 0;
    bits.delete();
    msels.delete();
    bytes_v[0] = b0;
    bytes_v[1] = b1;
    nb = n; idx = 0; gap = g; wait_cnt = 0;
    waiting = 1'b0; hs_pend = 1'b0; tgt_nack = nk;
    scl_p = 1'b1; msel_p = 1'b0; busy_p = 1'b0;
    tx_data = b0;
    tx_last = (n == 1);
    tx_valid = 1'b1;
    addr = a;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_frame(input string nm, input logic [6:0] a, input logic [7:0] b0,
                           input logic [7:0] b1, input int n, input bit nk, input int g,
                           input logic t0, input logic t1, input int exp_len, input bit poke);
    logic eb[$];
    logic em[$];
    logic [7:0] bv;
    int bad_b, bad_m, exp_rdy;
    bit poked;
    poked = 1'b0;
    init_frame(a, b0, b1, n, nk, g);
    check($sformatf("%s busy_after_start", nm), busy, 1'b1);
    check($sformatf("%s nack_cleared", nm), nack, 1'b0);
    for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
      step();
      if (poke && !poked && rises == 3) begin
        start = 1'b1;
        addr  = 7'h11;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    if (done_cnt == 0) check($sformatf("%s timeout", nm), 0, 1);
    repeat (6) step();

    for (int i = 6; i >= 0; i--) begin eb.push_back(a[i]); em.push_back(1'b0); end
    eb.push_back(1'b0); em.push_back(1'b0);
    eb.push_back(1'b1); em.push_back(1'b0);
    if (!nk) begin
      for (int j = 0; j < n; j++) begin
        bv = bytes_v[j];
        for (int i = 7; i >= 0; i--) begin eb.push_back(bv[i]); em.push_back(1'b1); end
        eb.push_back(j == 0 ? t0 : t1);
        em.push_back(1'b1);
      end
    end
    eb.push_back(1'b0); em.push_back(1'b0);

    check($sformatf("%s scl_rises", nm), bits.size(), eb.size());
    bad_b = 0;
    bad_m = 0;
    for (int i = 0; i < eb.size() && i < bits.size(); i++) begin
      if (bits[i] !== eb[i]) bad_b++;
      if (msels[i] !== em[i]) bad_m++;
    end
    check($sformatf("%s sda_bits_bad", nm), bad_b, 0);
    check($sformatf("%s modesel_bits_bad", nm), bad_m, 0);
    check($sformatf("%s frame_len", nm), done_cyc - start_cyc, exp_len);
    check($sformatf("%s done_count", nm), done_cnt, 1);
    check($sformatf("%s nack", nm), nack, nk);
    check($sformatf("%s modesel_glitch", nm), glitch, 0);
    exp_rdy = nk ? 0 : (n + ((g > 0) ? g - 1 : 0));
    check($sformatf("%s ready_cycles", nm), ready_cnt, exp_rdy);
    if (n == 1) check($sformatf("%s modesel_cycles", nm), msel_cnt, nk ? 0 : 18 * CLK_DIV);
    check($sformatf("%s idle_pins", nm), {scl, sda_o, sda_modesel, busy}, 4'b1100);
  endtask

  initial begin
    tbl[0] = '{a: 7'h2A, d: 8'hA5, nk: 1'b0, t: 1'b1, len: 161};
    tbl[1] = '{a: 7'h55, d: 8'h07, nk: 1'b0, t: 1'b0, len: 161};
    tbl[2] = '{a: 7'h7F, d: 8'h00, nk: 1'b0, t: 1'b1, len: 161};
    tbl[3] = '{a: 7'h01, d: 8'h80, nk: 1'b0, t: 1'b0, len: 161};
    tbl[4] = '{a: 7'h2A, d: 8'h5A, nk: 1'b1, t: 1'b0, len: 88};

    rst_i = 1'b1; start = 1'b0; addr = 7'h00; tx_data = 8'h00;
    tx_valid = 1'b0; tx_last = 1'b0; sda_i = 1'b1;
    #2 rst_i = 1'b0;
    #20;
    check("reset_outputs", {scl, sda_o, sda_modesel, tx_ready, busy, done, nack}, 7'b1100000);
    @(negedge clk);
    rst_i = 1'b1;

    for (int v = 0; v < 5; v++) begin
      run_frame($sformatf("vec%0d", v), tbl[v].a, tbl[v].d, 8'h00, 1, tbl[v].nk, 0,
                tbl[v].t, 1'b0, tbl[v].len, 1'b0);
    end

    run_frame("after_nack", 7'h2A, 8'hA5, 8'h00, 1, 1'b0, 0, 1'b1, 1'b0, 161, 1'b0);
    run_frame("two_byte_gap", 7'h33, 8'hC3, 8'h01, 2, 1'b0, 10, 1'b1, 1'b0, 243, 1'b0);
    run_frame("start_while_busy", 7'h2A, 8'hA5, 8'h00, 1, 1'b0, 0, 1'b1, 1'b0, 161, 1'b1);

    init_frame(7'h2A, 8'hA5, 8'h00, 1, 1'b0, 0);
    for (int k = 0; k < 1000 && !(rises == 12 && !scl); k++) step();
    check("reached_data_bit3", rises, 12);
    #2 rst_i = 1'b0;
    #1;
    check("midframe_reset_outputs", {scl, sda_o, sda_modesel, tx_ready, busy, done, nack}, 7'b1100000);
    @(negedge clk);
    rst_i = 1'b1;
    run_frame("post_reset", 7'h2A, 8'hA5, 8'h00, 1, 1'b0, 0, 1'b1, 1'b0, 161, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
